// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: ALU operation codes, ALUOp encodings
// and bit positions inside the WB/M control bundles.
package ex_stage_pkg;

  typedef enum logic [2:0] {
    AluAdd,
    AluSub,
    AluAnd,
    AluOr,
    AluXor,
    AluSll,
    AluSrl,
    AluSra
  } alu_ctrl_e;

  localparam logic [1:0] AluOpAdd    = 2'b00;
  localparam logic [1:0] AluOpBranch = 2'b01;
  localparam logic [1:0] AluOpFunct  = 2'b10;

  localparam int unsigned WbRegWrite = 1;
  localparam int unsigned WbMemToReg = 0;
  localparam int unsigned MBranch    = 2;
  localparam int unsigned MMemRead   = 1;
  localparam int unsigned MMemWrite  = 0;

  // funct is {instr[30], instr[14:12]}; unknown combinations fall back to ADD.
  function automatic alu_ctrl_e alu_decode(input logic [1:0] aluop, input logic [3:0] funct);
    alu_ctrl_e ctrl;
    ctrl = AluAdd;
    if (aluop == AluOpBranch) begin
      ctrl = AluSub;
    end else if (aluop == AluOpFunct) begin
      case (funct)
        4'b1000: ctrl = AluSub;
        4'b0111: ctrl = AluAnd;
        4'b0110: ctrl = AluOr;
        4'b0100: ctrl = AluXor;
        4'b0001: ctrl = AluSll;
        4'b0101: ctrl = AluSrl;
        4'b1101: ctrl = AluSra;
        default: ctrl = AluAdd;
      endcase
    end
    return ctrl;
  endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational ALU for the execute stage; results wrap modulo 2^XLEN and the
// shift amount is the low six bits of operand b.
module ex_stage_alu
  import ex_stage_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  alu_ctrl_e       op_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o
);

  logic [5:0] shamt;

  assign shamt = b_i[5:0];

  always_comb begin
    result_o = '0;
    unique case (op_i)
      AluAdd:  result_o = a_i + b_i;
      AluSub:  result_o = a_i - b_i;
      AluAnd:  result_o = a_i & b_i;
      AluOr:   result_o = a_i | b_i;
      AluXor:  result_o = a_i ^ b_i;
      AluSll:  result_o = a_i << shamt;
      AluSrl:  result_o = a_i >> shamt;
      AluSra:  result_o = $signed(a_i) >>> shamt;
      default: result_o = a_i + b_i;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch target and the EX/MEM pipeline
// register with stall/flush/bubble handling.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [XLEN-1:0] id_rdata1,
  input  logic [XLEN-1:0] id_rdata2,
  input  logic [XLEN-1:0] id_imm,
  input  logic [3:0]      id_funct,
  input  logic [1:0]      id_wb,
  input  logic [2:0]      id_m,
  input  logic [1:0]      id_aluop,
  input  logic            id_alusrc,
  input  logic            wb_regwrite,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            exm_valid,
  output logic [1:0]      exm_wb,
  output logic [2:0]      exm_m,
  output logic [4:0]      exm_rd,
  output logic [XLEN-1:0] exm_alu_result,
  output logic [XLEN-1:0] exm_store_data,
  output logic [XLEN-1:0] exm_branch_target,
  output logic            exm_zero,
  output logic            exm_branch_taken
);

  logic            valid_q, valid_d;
  logic [1:0]      wb_q, wb_d;
  logic [2:0]      m_q, m_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] alu_result_q, alu_result_d;
  logic [XLEN-1:0] store_data_q, store_data_d;
  logic [XLEN-1:0] target_q, target_d;
  logic            zero_q, zero_d;
  logic            taken_q, taken_d;

  logic [XLEN-1:0] op_a, fwd_b, op_b, alu_result;
  logic            alu_zero, exm_fwd_a, exm_fwd_b, wb_fwd_a, wb_fwd_b;

  // Forward from the registered EX/MEM values, so a stalled stage still feeds them back.
  assign exm_fwd_a = valid_q && wb_q[WbRegWrite] && (rd_q != 5'd0) && (rd_q == id_rs1);
  assign exm_fwd_b = valid_q && wb_q[WbRegWrite] && (rd_q != 5'd0) && (rd_q == id_rs2);
  assign wb_fwd_a  = wb_regwrite && (wb_rd != 5'd0) && (wb_rd == id_rs1);
  assign wb_fwd_b  = wb_regwrite && (wb_rd != 5'd0) && (wb_rd == id_rs2);

  always_comb begin
    op_a  = id_rdata1;
    fwd_b = id_rdata2;
    if (exm_fwd_a)     op_a = alu_result_q;
    else if (wb_fwd_a) op_a = wb_data;
    if (exm_fwd_b)     fwd_b = alu_result_q;
    else if (wb_fwd_b) fwd_b = wb_data;
  end

  assign op_b = id_alusrc ? id_imm : fwd_b;

  ex_stage_alu #(
    .XLEN(XLEN)
  ) u_alu (
    .a_i     (op_a),
    .b_i     (op_b),
    .op_i    (alu_decode(id_aluop, id_funct)),
    .result_o(alu_result),
    .zero_o  (alu_zero)
  );

  always_comb begin
    valid_d      = valid_q;
    wb_d         = wb_q;
    m_d          = m_q;
    rd_d         = rd_q;
    alu_result_d = alu_result_q;
    store_data_d = store_data_q;
    target_d     = target_q;
    zero_d       = zero_q;
    taken_d      = taken_q;
    if (flush || !stall) begin
      rd_d         = id_rd;
      alu_result_d = alu_result;
      store_data_d = fwd_b;
      target_d     = id_pc + (id_imm << 1);
      zero_d       = alu_zero;
      // Flush and an invalid ID bundle both insert a bubble; flush overrides stall.
      if (flush || !id_valid) begin
        valid_d = 1'b0;
        wb_d    = 2'b00;
        m_d     = 3'b000;
        taken_d = 1'b0;
      end else begin
        valid_d = 1'b1;
        wb_d    = id_wb;
        m_d     = id_m;
        taken_d = id_m[MBranch] & alu_zero;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q      <= 1'b0;
      wb_q         <= '0;
      m_q          <= '0;
      rd_q         <= '0;
      alu_result_q <= '0;
      store_data_q <= '0;
      target_q     <= '0;
      zero_q       <= 1'b0;
      taken_q      <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      wb_q         <= wb_d;
      m_q          <= m_d;
      rd_q         <= rd_d;
      alu_result_q <= alu_result_d;
      store_data_q <= store_data_d;
      target_q     <= target_d;
      zero_q       <= zero_d;
      taken_q      <= taken_d;
    end
  end

  assign exm_valid         = valid_q;
  assign exm_wb            = wb_q;
  assign exm_m             = m_q;
  assign exm_rd            = rd_q;
  assign exm_alu_result    = alu_result_q;
  assign exm_store_data    = store_data_q;
  assign exm_branch_target = target_q;
  assign exm_zero          = zero_q;
  assign exm_branch_taken  = taken_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios followed by random traffic
// compared against a behavioural model of the EX/MEM register contents.
module tb_ex_stage;

  localparam int unsigned XLEN = 64;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            stall, flush, id_valid, id_alusrc, wb_regwrite;
  logic [XLEN-1:0] id_pc, id_rdata1, id_rdata2, id_imm, wb_data;
  logic [4:0]      id_rs1, id_rs2, id_rd, wb_rd;
  logic [3:0]      id_funct;
  logic [1:0]      id_wb, id_aluop;
  logic [2:0]      id_m;
  logic            exm_valid, exm_zero, exm_branch_taken;
  logic [1:0]      exm_wb;
  logic [2:0]      exm_m;
  logic [4:0]      exm_rd;
  logic [XLEN-1:0] exm_alu_result, exm_store_data, exm_branch_target;

  int n_assert = 0;
  int n_fail   = 0;

  // Model of what EX/MEM should hold; m_known is false when data fields are don't-care.
  logic            m_valid, m_zero, m_taken, m_known;
  logic [1:0]      m_wb;
  logic [2:0]      m_m;
  logic [4:0]      m_rd;
  logic [XLEN-1:0] m_alu, m_store, m_tgt;

  always #5 clk = ~clk;

  ex_stage #(
    .XLEN(XLEN)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .stall            (stall),
    .flush            (flush),
    .id_valid         (id_valid),
    .id_pc            (id_pc),
    .id_rs1           (id_rs1),
    .id_rs2           (id_rs2),
    .id_rd            (id_rd),
    .id_rdata1        (id_rdata1),
    .id_rdata2        (id_rdata2),
    .id_imm           (id_imm),
    .id_funct         (id_funct),
    .id_wb            (id_wb),
    .id_m             (id_m),
    .id_aluop         (id_aluop),
    .id_alusrc        (id_alusrc),
    .wb_regwrite      (wb_regwrite),
    .wb_rd            (wb_rd),
    .wb_data          (wb_data),
    .exm_valid        (exm_valid),
    .exm_wb           (exm_wb),
    .exm_m            (exm_m),
    .exm_rd           (exm_rd),
    .exm_alu_result   (exm_alu_result),
    .exm_store_data   (exm_store_data),
    .exm_branch_target(exm_branch_target),
    .exm_zero         (exm_zero),
    .exm_branch_taken (exm_branch_taken)
  );

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] ref_value(input logic [4:0] rs, input logic [XLEN-1:0] rf);
    if (m_valid && m_wb[1] && rs != 0 && rs == m_rd) return m_alu;
    if (wb_regwrite && wb_rd != 0 && wb_rd == rs) return wb_data;
    return rf;
  endfunction

  function automatic logic [XLEN-1:0] ref_alu(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    int sh;
    sh = int'(b[5:0]);
    if (id_aluop == 2'b01) return a - b;
    if (id_aluop != 2'b10) return a + b;
    case (id_funct)
      4'b1000: return a - b;
      4'b0111: return a & b;
      4'b0110: return a | b;
      4'b0100: return a ^ b;
      4'b0001: return a << sh;
      4'b0101: return a >> sh;
      4'b1101: return XLEN'($signed(a) >>> sh);
      default: return a + b;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 0; m_wb = 0; m_m = 0; m_rd = 0; m_alu = 0; m_store = 0; m_tgt = 0;
    m_zero = 0; m_taken = 0; m_known = 1;
  endtask

  task automatic model_step();
    logic [XLEN-1:0] a, b2, res;
    logic bubble;
    if (stall && !flush) return;
    a      = ref_value(id_rs1, id_rdata1);
    b2     = ref_value(id_rs2, id_rdata2);
    res    = ref_alu(a, id_alusrc ? id_imm : b2);
    bubble = flush || !id_valid;
    m_valid = !bubble;
    m_wb    = bubble ? 2'b00 : id_wb;
    m_m     = bubble ? 3'b000 : id_m;
    m_taken = !bubble && id_m[2] && (res == 0);
    m_known = !bubble;
    if (!bubble) begin
      m_rd = id_rd; m_alu = res; m_store = b2; m_zero = (res == 0);
      m_tgt = id_pc + id_imm * 2;
    end
  endtask

  task automatic check_all(input string ctx);
    check({ctx, ".valid"}, XLEN'(exm_valid), XLEN'(m_valid));
    check({ctx, ".wb"}, XLEN'(exm_wb), XLEN'(m_wb));
    check({ctx, ".m"}, XLEN'(exm_m), XLEN'(m_m));
    check({ctx, ".taken"}, XLEN'(exm_branch_taken), XLEN'(m_taken));
    if (m_known) begin
      check({ctx, ".rd"}, XLEN'(exm_rd), XLEN'(m_rd));
      check({ctx, ".alu"}, exm_alu_result, m_alu);
      check({ctx, ".store"}, exm_store_data, m_store);
      check({ctx, ".target"}, exm_branch_target, m_tgt);
      check({ctx, ".zero"}, XLEN'(exm_zero), XLEN'(m_zero));
    end
  endtask

  // Inputs are applied 1 time unit after an edge; outputs are sampled at the same point.
  task automatic step(input string ctx);
    model_step();
    @(posedge clk);
    #1;
    check_all(ctx);
  endtask

  task automatic base_inputs();
    stall = 0; flush = 0; id_valid = 1; id_pc = 0; id_rs1 = 1; id_rs2 = 2; id_rd = 5;
    id_rdata1 = 0; id_rdata2 = 0; id_imm = 0; id_funct = 0; id_wb = 2'b10; id_m = 0;
    id_aluop = 2'b10; id_alusrc = 0; wb_regwrite = 0; wb_rd = 0; wb_data = 0;
  endtask

  task automatic rand_inputs();
    id_valid  = ($urandom_range(0, 7) != 0);
    id_pc     = {$urandom, $urandom};
    id_rs1    = 5'($urandom_range(0, 4));
    id_rs2    = 5'($urandom_range(0, 4));
    id_rd     = 5'($urandom_range(0, 4));
    id_rdata1 = {$urandom, $urandom};
    id_rdata2 = ($urandom_range(0, 3) == 0) ? id_rdata1 : {$urandom, $urandom};
    id_imm    = ($urandom_range(0, 1) == 0) ? XLEN'($signed($urandom_range(0, 255)) - 128)
                                            : {$urandom, $urandom};
    id_funct  = 4'($urandom);
    id_wb     = 2'($urandom);
    id_m      = 3'($urandom);
    id_aluop  = 2'($urandom);
    id_alusrc = 1'($urandom);
    wb_regwrite = 1'($urandom);
    wb_rd     = 5'($urandom_range(0, 4));
    wb_data   = {$urandom, $urandom};
  endtask

  initial begin
    base_inputs();
    reset_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    #3 reset_n = 1;

    // ADD 5 + 7
    @(posedge clk); #1;
    id_rdata1 = 5; id_rdata2 = 7;
    step("add");
    check("add.result", exm_alu_result, 12);
    check("add.zero", XLEN'(exm_zero), 0);

    // Back-to-back EX/MEM forward
    id_aluop = 2'b00; id_rd = 3; id_rdata1 = 64'h10; id_rdata2 = 0;
    step("dep1");
    id_rs1 = 3; id_rdata1 = 0; id_imm = 4; id_alusrc = 1; id_rd = 6;
    step("dep2");
    check("dep2.result", exm_alu_result, 64'h14);

    // Double hazard: EX/MEM wins over MEM/WB
    id_rs1 = 1; id_rdata1 = 9; id_imm = 0; id_rd = 4;
    step("dh1");
    id_rs1 = 4; id_rdata1 = 100; wb_regwrite = 1; wb_rd = 4; wb_data = 2; id_rd = 7;
    step("dh2");
    check("dh2.result", exm_alu_result, 9);
    // x0 is never forwarded
    id_rs1 = 1; id_rdata1 = 1; id_rd = 0;
    step("x0a");
    id_rs1 = 0; id_rdata1 = 64'h33; wb_rd = 0; id_rd = 8;
    step("x0b");
    check("x0b.result", exm_alu_result, 64'h33);

    // BEQ taken
    wb_regwrite = 0; id_aluop = 2'b01; id_m = 3'b100; id_wb = 2'b00; id_rs1 = 6; id_rs2 = 7;
    id_rdata1 = 64'h55; id_rdata2 = 64'h55; id_pc = 64'h100; id_imm = 8; id_alusrc = 0;
    step("beq");
    check("beq.zero", XLEN'(exm_zero), 1);
    check("beq.taken", XLEN'(exm_branch_taken), 1);
    check("beq.target", exm_branch_target, 64'h110);

    // Stall three cycles with changing inputs, then stall+flush
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      stall = 1;
      step("stall");
      check("stall.target", exm_branch_target, 64'h110);
    end
    flush = 1;
    step("stallflush");
    check("sf.valid", XLEN'(exm_valid), 0);
    check("sf.wb", XLEN'(exm_wb), 0);
    check("sf.m", XLEN'(exm_m), 0);

    // Asynchronous reset mid-cycle during valid traffic
    base_inputs();
    id_rdata1 = 64'hAB; id_m = 3'b010;
    step("pre_reset");
    id_rdata1 = 64'hCD;
    #3 reset_n = 0;
    model_reset();
    #1 check_all("async_reset");
    #2 reset_n = 1;
    step("post_reset");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 9) == 0);
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Parameter XLEN, default 64, datapath width.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset_n  in  1  reset, asynchronous, active-low.
REQ-004 stall  in  1  hold all EX/MEM outputs this cycle.
REQ-005 flush  in  1  load a bubble into EX/MEM this cycle.
REQ-006 id_valid  in  1  ID/EX bundle holds a real instruction.
REQ-007 id_pc  in  XLEN  instruction address.
REQ-008 id_rs1, id_rs2, id_rd  in  5 each  register indices.
REQ-009 id_rdata1, id_rdata2  in  XLEN each  register-file read data.
REQ-010 id_imm  in  XLEN  sign-extended immediate.
REQ-011 id_funct  in  4  {instr[30], instr[14:12]}.
REQ-012 id_wb  in  2  [1] RegWrite, [0] MemtoReg.
REQ-013 id_m  in  3  [2] Branch, [1] MemRead, [0] MemWrite.
REQ-014 id_aluop  in  2  00 add, 01 branch-compare, 10 funct-decoded.
REQ-015 id_alusrc  in  1  0 operand B = forwarded rs2, 1 = id_imm.
REQ-016 wb_regwrite, wb_rd (5), wb_data (XLEN)  in  MEM/WB writeback for forwarding.
REQ-017 exm_valid, exm_wb (2), exm_m (3), exm_rd (5)  out  registered control/index.
REQ-018 exm_alu_result, exm_store_data, exm_branch_target  out  XLEN each  registered.
REQ-019 exm_zero, exm_branch_taken  out  1 each  registered.

Function
REQ-020 ALU control: aluop 00 -> ADD; 01 -> SUB; 10 -> funct 0000 ADD, 1000 SUB, 0111 AND, 0110 OR, 0100 XOR, 0001 SLL, 0101 SRL, 1101 SRA; other funct -> ADD.
REQ-021 Shift amount = operand B[5:0]; SRA sign-fills.
REQ-022 Arithmetic is modulo 2^XLEN; overflow ignored.
REQ-023 Forward operand A/rs2: EX/MEM match (exm_valid, exm_wb[1], exm_rd != 0, exm_rd == rs) -> exm_alu_result; else MEM/WB match (wb_regwrite, wb_rd != 0, wb_rd == rs) -> wb_data; else id_rdata.
REQ-024 EX/MEM match has priority over MEM/WB; register x0 never forwarded.
REQ-025 exm_store_data = forwarded rs2, independent of alusrc.
REQ-026 Branch target = id_pc + (id_imm << 1), modulo 2^XLEN.
REQ-027 exm_zero = (ALU result == 0); exm_branch_taken = id_m[2] & zero & id_valid.
REQ-028 Latency one cycle: inputs sampled at rising clk appear on exm_* after that edge.
REQ-029 stall=1, flush=0: every exm_* holds its value.
REQ-030 flush=1: exm_valid, exm_wb, exm_m, exm_branch_taken <= 0; data outputs don't-care; flush beats stall.
REQ-031 id_valid=0 (no flush/stall): load as flush (bubble).
REQ-032 Forwarding from EX/MEM uses currently registered values even during stall.

Reset
REQ-033 reset_n low asynchronously clears every exm_* output to 0, regardless of clk.
REQ-034 First edge after reset_n rises captures normally.

Structure
REQ-035 Shared package holds ALU-control codes, aluop encodings, WB/M bit indices.
REQ-036 One sub-module, alu (combinational: a, b, op -> result, zero); forwarding and EX/MEM register in ex_stage.

Verification
REQ-037 ADD: aluop 10, funct 0000, rdata1=5, rdata2=7, no forwarding -> exm_alu_result=12, exm_zero=0 next edge.
REQ-038 Back-to-back dependency: instr1 rd=3 result 0x10; instr2 rs1=3, rdata1=0 stale, imm=4, alusrc=1 -> result 0x14 (EX/MEM forward).
REQ-039 Double hazard: exm_rd=4 result 9, wb_rd=4 data 2, rs1=4 -> operand A=9; rd=0 with all matches -> id_rdata used.
REQ-040 BEQ: aluop 01, id_m=100, rdata1=rdata2=0x55, pc=0x100, imm=8 -> exm_zero=1, branch_taken=1, target=0x110.
REQ-041 stall held 3 cycles with changing inputs -> exm_* unchanged; stall+flush together -> exm_valid=0, exm_wb=0, exm_m=0.
REQ-042 reset_n pulsed low mid-cycle during valid traffic -> all exm_* read 0 before next clk edge.
